// File: rtl/register_tree_kv.sv
// register_tree_kv: binary-tree priority queue of {key, value} pairs with the best key held at
// the root. Inserts and removals settle at the root in one clock, then walk down one level per clock.
module register_tree_kv #(
   parameter int unsigned  LEVELS     = 4,
   parameter int unsigned  KEY_WIDTH  = 16,
   parameter int unsigned  VAL_WIDTH  = 8,
   parameter int unsigned  MIN_FIRST  = 0,
   localparam int unsigned QUEUE_SIZE = (2 ** LEVELS) - 1,
   localparam int unsigned CNT_WIDTH  = $clog2(QUEUE_SIZE + 1)
) (
   input  logic                 i_CLK,
   input  logic                 i_RST,
   input  logic                 i_wrt,
   input  logic                 i_read,
   input  logic [KEY_WIDTH-1:0] i_key,
   input  logic [VAL_WIDTH-1:0] i_value,
   output logic                 o_ready,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [CNT_WIDTH-1:0] o_count,
   output logic                 o_valid,
   output logic [KEY_WIDTH-1:0] o_key,
   output logic [VAL_WIDTH-1:0] o_value,
   output logic                 o_err
);

   localparam int unsigned IDX_WIDTH  = LEVELS;
   localparam int unsigned LVL_WIDTH  = (LEVELS > 1) ? $clog2(LEVELS) : 1;
   localparam int unsigned FIRST_LEAF = 2 ** (LEVELS - 1);

   typedef enum logic [1:0] {StIdle, StInsert, StSift, StWait} state_e;
   typedef logic [IDX_WIDTH-1:0] idx_t;

   state_e               state_q, state_d;
   logic [LVL_WIDTH-1:0] lvl_q, lvl_d;
   idx_t                 pos_q, pos_d;
   logic                 cx_vld_q, cx_vld_d;
   logic [KEY_WIDTH-1:0] cx_key_q, cx_key_d;
   logic [VAL_WIDTH-1:0] cx_val_q, cx_val_d;
   logic                 dec_q, dec_d;
   logic                 err_q, err_d;

   // Node storage in heap order: node n has children 2n and 2n+1.
   logic                 node_vld_q [1:QUEUE_SIZE];
   logic                 node_vld_d [1:QUEUE_SIZE];
   logic [KEY_WIDTH-1:0] node_key_q [1:QUEUE_SIZE];
   logic [KEY_WIDTH-1:0] node_key_d [1:QUEUE_SIZE];
   logic [VAL_WIDTH-1:0] node_val_q [1:QUEUE_SIZE];
   logic [VAL_WIDTH-1:0] node_val_d [1:QUEUE_SIZE];
   logic [CNT_WIDTH-1:0] node_occ_q [1:QUEUE_SIZE];
   logic [CNT_WIDTH-1:0] node_occ_d [1:QUEUE_SIZE];

   logic                 cmd_ins, cmd_deq, cmd_rep, acc_ins, acc_sift;
   logic                 step_en, step_ins, step_dec, step_done;
   idx_t                 sh, li, ri, bi, ins_dir;
   logic                 leaf, lv, rv, bv;
   logic                 sx_vld;
   logic [KEY_WIDTH-1:0] sx_key;
   logic [VAL_WIDTH-1:0] sx_val;

   function automatic logic better(input logic [KEY_WIDTH-1:0] a, input logic [KEY_WIDTH-1:0] b);
      if (MIN_FIRST != 0) return a < b;
      return a > b;
   endfunction

   assign cmd_ins  = i_wrt & ~i_read;
   assign cmd_deq  = i_read & ~i_wrt;
   assign cmd_rep  = i_wrt & i_read;
   // Replace on an empty queue degenerates to a plain insert.
   assign acc_ins  = (cmd_ins & ~o_full) | (cmd_rep & o_empty);
   assign acc_sift = (cmd_deq | cmd_rep) & ~o_empty;

   always_comb begin
      step_en  = 1'b0;
      step_ins = 1'b0;
      step_dec = dec_q;
      sh       = pos_q;
      sx_vld   = cx_vld_q;
      sx_key   = cx_key_q;
      sx_val   = cx_val_q;
      err_d    = i_wrt | i_read;
      unique case (state_q)
         StIdle: begin
            sh       = idx_t'(1);
            sx_vld   = ~cmd_deq;
            sx_key   = i_key;
            sx_val   = i_value;
            step_dec = cmd_deq;
            step_en  = acc_ins | acc_sift;
            step_ins = acc_ins;
            err_d    = (i_wrt | i_read) & ~(acc_ins | acc_sift);
         end
         StInsert: begin
            step_en  = 1'b1;
            step_ins = 1'b1;
         end
         StSift:  step_en = 1'b1;
         default: ;
      endcase
   end

   // Neighbourhood of the node being worked on this cycle.
   assign leaf    = (sh >= idx_t'(FIRST_LEAF));
   assign li      = leaf ? sh : (sh << 1);
   assign ri      = leaf ? sh : ((sh << 1) | idx_t'(1));
   assign lv      = ~leaf & node_vld_q[li];
   assign rv      = ~leaf & node_vld_q[ri];
   assign bv      = lv | rv;
   assign bi      = (lv & rv) ? (better(node_key_q[ri], node_key_q[li]) ? ri : li)
                              : (rv ? ri : li);
   assign ins_dir = (node_occ_q[ri] < node_occ_q[li]) ? ri : li;

   always_comb begin
      state_d    = state_q;
      lvl_d      = lvl_q;
      pos_d      = pos_q;
      dec_d      = dec_q;
      cx_vld_d   = sx_vld;
      cx_key_d   = sx_key;
      cx_val_d   = sx_val;
      node_vld_d = node_vld_q;
      node_key_d = node_key_q;
      node_val_d = node_val_q;
      node_occ_d = node_occ_q;
      step_done  = 1'b0;

      if (step_en) begin
         if (step_ins) begin
            node_occ_d[sh] = node_occ_q[sh] + CNT_WIDTH'(1);
            if (!node_vld_q[sh]) begin
               node_vld_d[sh] = 1'b1;
               node_key_d[sh] = sx_key;
               node_val_d[sh] = sx_val;
               step_done      = 1'b1;
            end else begin
               // Keep the better pair here and carry the worse one into the emptier subtree.
               if (better(sx_key, node_key_q[sh])) begin
                  node_key_d[sh] = sx_key;
                  node_val_d[sh] = sx_val;
                  cx_key_d       = node_key_q[sh];
                  cx_val_d       = node_val_q[sh];
               end
               pos_d     = ins_dir;
               step_done = leaf;
            end
         end else begin
            if (step_dec) node_occ_d[sh] = node_occ_q[sh] - CNT_WIDTH'(1);
            // The hole at sh is filled by the carried pair unless a child beats it.
            if (bv && (!sx_vld || better(node_key_q[bi], sx_key))) begin
               node_vld_d[sh] = 1'b1;
               node_key_d[sh] = node_key_q[bi];
               node_val_d[sh] = node_val_q[bi];
               pos_d          = bi;
            end else begin
               node_vld_d[sh] = sx_vld;
               node_key_d[sh] = sx_vld ? sx_key : '0;
               node_val_d[sh] = sx_vld ? sx_val : '0;
               step_done      = 1'b1;
            end
         end
      end

      // Busy time is fixed at LEVELS-1 cycles regardless of where the walk stops.
      if (state_q == StIdle) begin
         if (step_en && (LEVELS > 1)) begin
            lvl_d = LVL_WIDTH'(1);
            dec_d = step_dec;
            if (step_done)     state_d = StWait;
            else if (step_ins) state_d = StInsert;
            else               state_d = StSift;
         end
      end else if (lvl_q == LVL_WIDTH'(LEVELS - 1)) begin
         state_d = StIdle;
      end else begin
         lvl_d = lvl_q + LVL_WIDTH'(1);
         if (step_done) state_d = StWait;
      end
   end

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q  <= StIdle;
         lvl_q    <= '0;
         pos_q    <= idx_t'(1);
         cx_vld_q <= 1'b0;
         cx_key_q <= '0;
         cx_val_q <= '0;
         dec_q    <= 1'b0;
         err_q    <= 1'b0;
         for (int unsigned i = 1; i <= QUEUE_SIZE; i++) begin
            node_vld_q[i] <= 1'b0;
            node_key_q[i] <= '0;
            node_val_q[i] <= '0;
            node_occ_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         lvl_q      <= lvl_d;
         pos_q      <= pos_d;
         cx_vld_q   <= cx_vld_d;
         cx_key_q   <= cx_key_d;
         cx_val_q   <= cx_val_d;
         dec_q      <= dec_d;
         err_q      <= err_d;
         node_vld_q <= node_vld_d;
         node_key_q <= node_key_d;
         node_val_q <= node_val_d;
         node_occ_q <= node_occ_d;
      end
   end

   assign o_ready = (state_q == StIdle);
   assign o_count = node_occ_q[1];
   assign o_empty = (node_occ_q[1] == '0);
   assign o_full  = (node_occ_q[1] == CNT_WIDTH'(QUEUE_SIZE));
   assign o_valid = node_vld_q[1];
   assign o_key   = node_key_q[1];
   assign o_value = node_val_q[1];
   assign o_err   = err_q;

endmodule

// File: tb/tb_register_tree_kv.sv
// Bench for register_tree_kv: table-driven fill/drain, hand-written corner sequences and
// random traffic against an unordered-list reference model.
module tb_register_tree_kv;

   localparam int unsigned QS = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        wrt = 1'b0, rd = 1'b0;
   logic [15:0] key = '0;
   logic [7:0]  val = '0;
   logic        ready, full, empty, valid, err;
   logic [3:0]  count;
   logic [15:0] okey;
   logic [7:0]  oval;

   logic        b_wrt = 1'b0, b_rd = 1'b0;
   logic [15:0] b_key = '0;
   logic [7:0]  b_val = '0;
   logic        b_ready, b_full, b_empty, b_valid, b_err;
   logic [2:0]  b_count;
   logic [15:0] b_okey;
   logic [7:0]  b_oval;

   register_tree_kv #(.LEVELS(4), .KEY_WIDTH(16), .VAL_WIDTH(8), .MIN_FIRST(0)) dut (
      .i_CLK(clk), .i_RST(rst), .i_wrt(wrt), .i_read(rd), .i_key(key), .i_value(val),
      .o_ready(ready), .o_full(full), .o_empty(empty), .o_count(count), .o_valid(valid),
      .o_key(okey), .o_value(oval), .o_err(err)
   );

   register_tree_kv #(.LEVELS(3), .KEY_WIDTH(16), .VAL_WIDTH(8), .MIN_FIRST(1)) dut_min (
      .i_CLK(clk), .i_RST(rst), .i_wrt(b_wrt), .i_read(b_rd), .i_key(b_key), .i_value(b_val),
      .o_ready(b_ready), .o_full(b_full), .o_empty(b_empty), .o_count(b_count),
      .o_valid(b_valid), .o_key(b_okey), .o_value(b_oval), .o_err(b_err)
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] mk[$];
   logic [7:0]  mv[$];

   typedef struct {
      logic        w;
      logic        r;
      logic [15:0] k;
      logic [7:0]  v;
      logic [15:0] ek;
      logic [7:0]  ev;
      int          ec;
      logic        eerr;
   } vec_t;

   vec_t tbl[32];

   function automatic vec_t mkv(input logic w, input logic r, input logic [15:0] k,
                                input logic [7:0] v, input logic [15:0] ek,
                                input logic [7:0] ev, input int ec, input logic eerr);
      vec_t t;
      t.w = w; t.r = r; t.k = k; t.v = v; t.ek = ek; t.ev = ev; t.ec = ec; t.eerr = eerr;
      return t;
   endfunction

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ready && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready) chk("ready_timeout", ready, 1);
   endtask

   task automatic issue(input logic w, input logic r, input logic [15:0] k, input logic [7:0] v);
      wait_ready();
      wrt = w; rd = r; key = k; val = v;
      @(posedge clk); #1;
      wrt = 1'b0; rd = 1'b0;
   endtask

   task automatic b_issue(input logic w, input logic r, input logic [15:0] k);
      int n = 0;
      while (!b_ready && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      if (!b_ready) chk("min_ready_timeout", b_ready, 1);
      b_wrt = w; b_rd = r; b_key = k; b_val = k[7:0];
      @(posedge clk); #1;
      b_wrt = 1'b0; b_rd = 1'b0;
   endtask

   function automatic int best_idx();
      int b = -1;
      foreach (mk[i]) if (b < 0 || mk[i] > mk[b]) b = i;
      return b;
   endfunction

   function automatic bit in_model(input logic [15:0] k);
      foreach (mk[i]) if (mk[i] == k) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_root(input string name, input logic exp_err);
      int b = best_idx();
      int unsigned ek = 0;
      int unsigned ev = 0;
      if (b >= 0) begin
         ek = mk[b];
         ev = mv[b];
      end
      chk({name, "_key"}, okey, ek);
      chk({name, "_value"}, oval, ev);
      chk({name, "_count"}, count, mk.size());
      chk({name, "_err"}, err, exp_err);
      chk({name, "_full"}, full, mk.size() == QS);
      chk({name, "_empty"}, empty, mk.size() == 0);
      chk({name, "_valid"}, valid, mk.size() != 0);
   endtask

   task automatic do_op(input string name, input logic w, input logic r, input logic [15:0] k,
                        input logic [7:0] v);
      logic exp_err = 1'b0;
      int b;
      if (w && !r) begin
         if (mk.size() == QS) exp_err = 1'b1;
         else begin
            mk.push_back(k); mv.push_back(v);
         end
      end else if (r && !w) begin
         if (mk.size() == 0) exp_err = 1'b1;
         else begin
            b = best_idx(); mk.delete(b); mv.delete(b);
         end
      end else if (w && r) begin
         if (mk.size() > 0) begin
            b = best_idx(); mk.delete(b); mv.delete(b);
         end
         mk.push_back(k); mv.push_back(v);
      end
      issue(w, r, k, v);
      check_root(name, exp_err);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Fill with distinct keys (value = insertion index), overflow, drain, underflow.
      tbl[0]  = mkv(1, 0, 5,    1,  5,    1,  1, 0);
      tbl[1]  = mkv(1, 0, 900,  2,  900,  2,  2, 0);
      tbl[2]  = mkv(1, 0, 17,   3,  900,  2,  3, 0);
      tbl[3]  = mkv(1, 0, 1024, 4,  1024, 4,  4, 0);
      tbl[4]  = mkv(1, 0, 3,    5,  1024, 4,  5, 0);
      tbl[5]  = mkv(1, 0, 250,  6,  1024, 4,  6, 0);
      tbl[6]  = mkv(1, 0, 64,   7,  1024, 4,  7, 0);
      tbl[7]  = mkv(1, 0, 777,  8,  1024, 4,  8, 0);
      tbl[8]  = mkv(1, 0, 12,   9,  1024, 4,  9, 0);
      tbl[9]  = mkv(1, 0, 499,  10, 1024, 4, 10, 0);
      tbl[10] = mkv(1, 0, 1000, 11, 1024, 4, 11, 0);
      tbl[11] = mkv(1, 0, 33,   12, 1024, 4, 12, 0);
      tbl[12] = mkv(1, 0, 600,  13, 1024, 4, 13, 0);
      tbl[13] = mkv(1, 0, 8,    14, 1024, 4, 14, 0);
      tbl[14] = mkv(1, 0, 150,  15, 1024, 4, 15, 0);
      tbl[15] = mkv(1, 0, 9999, 200, 1024, 4, 15, 1);
      tbl[16] = mkv(0, 1, 0, 0, 1000, 11, 14, 0);
      tbl[17] = mkv(0, 1, 0, 0, 900,  2,  13, 0);
      tbl[18] = mkv(0, 1, 0, 0, 777,  8,  12, 0);
      tbl[19] = mkv(0, 1, 0, 0, 600,  13, 11, 0);
      tbl[20] = mkv(0, 1, 0, 0, 499,  10, 10, 0);
      tbl[21] = mkv(0, 1, 0, 0, 250,  6,   9, 0);
      tbl[22] = mkv(0, 1, 0, 0, 150,  15,  8, 0);
      tbl[23] = mkv(0, 1, 0, 0, 64,   7,   7, 0);
      tbl[24] = mkv(0, 1, 0, 0, 33,   12,  6, 0);
      tbl[25] = mkv(0, 1, 0, 0, 17,   3,   5, 0);
      tbl[26] = mkv(0, 1, 0, 0, 12,   9,   4, 0);
      tbl[27] = mkv(0, 1, 0, 0, 8,    14,  3, 0);
      tbl[28] = mkv(0, 1, 0, 0, 5,    1,   2, 0);
      tbl[29] = mkv(0, 1, 0, 0, 3,    5,   1, 0);
      tbl[30] = mkv(0, 1, 0, 0, 0,    0,   0, 0);
      tbl[31] = mkv(0, 1, 0, 0, 0,    0,   0, 1);

      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_valid", valid, 0);
      chk("rst_key", okey, 0);
      chk("rst_value", oval, 0);
      chk("rst_err", err, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_ready", ready, 1);

      for (int i = 0; i < 32; i++) begin
         issue(tbl[i].w, tbl[i].r, tbl[i].k, tbl[i].v);
         chk($sformatf("tbl%0d_key", i), okey, tbl[i].ek);
         chk($sformatf("tbl%0d_value", i), oval, tbl[i].ev);
         chk($sformatf("tbl%0d_count", i), count, tbl[i].ec);
         chk($sformatf("tbl%0d_err", i), err, tbl[i].eerr);
         chk($sformatf("tbl%0d_full", i), full, tbl[i].ec == 15);
         chk($sformatf("tbl%0d_empty", i), empty, tbl[i].ec == 0);
      end

      // Smallest-first build.
      b_issue(1, 0, 40);
      chk("min_enq40", b_okey, 40);
      b_issue(1, 0, 7);
      chk("min_enq7", b_okey, 7);
      b_issue(1, 0, 300);
      chk("min_enq300", b_okey, 7);
      chk("min_count3", b_count, 3);
      b_issue(0, 1, 0);
      chk("min_deq_key", b_okey, 40);
      chk("min_deq_value", b_oval, 40);
      chk("min_deq_count", b_count, 2);

      // Replace on a full queue whose root is 1024.
      mk.delete(); mv.delete();
      for (int i = 0; i < 15; i++) do_op("refill", 1, 0, tbl[i].k, tbl[i].v);
      do_op("replace", 1, 1, 2, 99);
      chk("replace_root", okey, 1000);
      for (int i = 0; i < 15; i++) begin
         do_op("drain2", 0, 1, 0, 0);
         if (i == 13) chk("replace_last", okey, 2);
      end

      // Command while busy is rejected and does not count.
      do_op("busy_enq", 1, 0, 10, 1);
      chk("busy_ready_n1", ready, 0);
      wrt = 1'b1; key = 20; val = 2;
      @(posedge clk); #1;
      wrt = 1'b0;
      chk("busy_err", err, 1);
      chk("busy_count", count, 1);
      chk("busy_key", okey, 10);
      chk("busy_ready_n2", ready, 0);
      @(posedge clk); #1;
      chk("busy_ready_n3", ready, 0);
      @(posedge clk); #1;
      chk("busy_ready_n4", ready, 1);
      chk("busy_err_clear", err, 0);

      // Random traffic against the model; keys kept unique so pairs are unambiguous.
      for (int i = 0; i < 200; i++) begin
         int unsigned op;
         logic [15:0] k;
         logic [7:0]  v;
         op = $urandom_range(0, 9);
         do k = 16'($urandom_range(0, 65535)); while (in_model(k));
         v = 8'($urandom);
         if (op < 5)      do_op("rnd_enq", 1, 0, k, v);
         else if (op < 8) do_op("rnd_deq", 0, 1, k, v);
         else             do_op("rnd_rep", 1, 1, k, v);
      end

      // Reset in the middle of an insert walk.
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mk.delete(); mv.delete();
      for (int i = 0; i < 10; i++) do_op("pre", 1, 0, 16'(100 + i * 3), 8'(i));
      do_op("sweep", 1, 0, 500, 55);
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      mk.delete(); mv.delete();
      @(posedge clk); #1;
      chk("midrst_count", count, 0);
      chk("midrst_empty", empty, 1);
      chk("midrst_ready", ready, 1);
      chk("midrst_err", err, 0);
      chk("midrst_key", okey, 0);
      do_op("after_rst", 1, 0, 77, 7);
      chk("after_rst_key77", okey, 77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
